// File: rtl/bcd_guess_checker_if.sv
// Keypad, target and display bundle for the BCD guessing game checker.
// The slave modport is the checker; the master modport is the game or keypad side.
interface bcd_guess_checker_if #(
  parameter int TRY_W = 4
);
  logic             new_game;
  logic [3:0]       T1000, T100, T10, T1;
  logic             key_valid;
  logic [3:0]       key_digit;
  logic             key_clear;
  logic             key_enter;
  logic [3:0]       G1000, G100, G10, G1;
  logic [2:0]       entry_cnt;
  logic [TRY_W-1:0] tries;
  logic             too_high, too_low;
  logic             win, lose;
  logic             playing;

  modport master (
    output new_game, T1000, T100, T10, T1, key_valid, key_digit, key_clear, key_enter,
    input  G1000, G100, G10, G1, entry_cnt, tries, too_high, too_low, win, lose, playing
  );

  modport slave (
    input  new_game, T1000, T100, T10, T1, key_valid, key_digit, key_clear, key_enter,
    output G1000, G100, G10, G1, entry_cnt, tries, too_high, too_low, win, lose, playing
  );
endinterface

// File: rtl/bcd_guess_checker.sv
// Captures a 4-digit BCD target, collects keypad guesses and grades them.
// Optional macro BCD_GUESS_REVEAL_EN: show the target on the display when the game is lost.
module bcd_guess_checker #(
  parameter int MAX_TRIES = 8,
  parameter int TRY_W     = 4
) (
  input logic               clk,
  input logic               rst,
  bcd_guess_checker_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ENTRY, CHECK, WIN, LOSE} state_t;

  state_t           state_reg, state_next;
  logic [3:0][3:0]  target_reg, target_next;
  logic [3:0][3:0]  guess_reg, guess_next;
  logic [2:0]       entry_cnt_reg, entry_cnt_next;
  logic [TRY_W-1:0] tries_reg, tries_next;
  logic             too_high_reg, too_high_next;
  logic             too_low_reg, too_low_next;
  logic             win_reg, win_next;
  logic             lose_reg, lose_next;

  logic guess_eq, guess_gt, last_try, enter_ok, digit_ok;

  // Packed BCD digits compare correctly as plain unsigned numbers.
  assign guess_eq = (guess_reg == target_reg);
  assign guess_gt = (guess_reg > target_reg);
  assign last_try = ((tries_reg + TRY_W'(1)) == TRY_W'(MAX_TRIES));
  assign enter_ok = bus.key_enter && (entry_cnt_reg == 3'd4);
  assign digit_ok = bus.key_valid && (bus.key_digit <= 4'd9) && (entry_cnt_reg < 3'd4);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (bus.new_game) begin
      state_next = ENTRY;
    end else begin
      case (state_reg)
        ENTRY: if (!bus.key_clear && enter_ok) state_next = CHECK;
        CHECK: begin
          if (guess_eq)      state_next = WIN;
          else if (last_try) state_next = LOSE;
          else               state_next = ENTRY;
        end
        default: state_next = state_reg;
      endcase
    end
  end

  always_comb begin
    target_next    = target_reg;
    guess_next     = guess_reg;
    entry_cnt_next = entry_cnt_reg;
    tries_next     = tries_reg;
    too_high_next  = too_high_reg;
    too_low_next   = too_low_reg;
    win_next       = win_reg;
    lose_next      = lose_reg;
    if (bus.new_game) begin
      target_next    = {bus.T1000, bus.T100, bus.T10, bus.T1};
      guess_next     = '0;
      entry_cnt_next = '0;
      tries_next     = '0;
      too_high_next  = 1'b0;
      too_low_next   = 1'b0;
      win_next       = 1'b0;
      lose_next      = 1'b0;
    end else begin
      case (state_reg)
        ENTRY: begin
          if (bus.key_clear) begin
            guess_next     = '0;
            entry_cnt_next = '0;
          end else if (!bus.key_enter && digit_ok) begin
            guess_next     = {guess_reg[2:0], bus.key_digit};
            entry_cnt_next = entry_cnt_reg + 3'd1;
          end
        end
        CHECK: begin
          tries_next    = tries_reg + TRY_W'(1);
          too_high_next = !guess_eq && guess_gt;
          too_low_next  = !guess_eq && !guess_gt;
          if (guess_eq) begin
            win_next = 1'b1;
          end else if (last_try) begin
            lose_next = 1'b1;
`ifdef BCD_GUESS_REVEAL_EN
            guess_next     = target_reg;
            entry_cnt_next = 3'd4;
`endif
          end else begin
            guess_next     = '0;
            entry_cnt_next = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      target_reg    <= '0;
      guess_reg     <= '0;
      entry_cnt_reg <= '0;
      tries_reg     <= '0;
      too_high_reg  <= 1'b0;
      too_low_reg   <= 1'b0;
      win_reg       <= 1'b0;
      lose_reg      <= 1'b0;
    end else begin
      target_reg    <= target_next;
      guess_reg     <= guess_next;
      entry_cnt_reg <= entry_cnt_next;
      tries_reg     <= tries_next;
      too_high_reg  <= too_high_next;
      too_low_reg   <= too_low_next;
      win_reg       <= win_next;
      lose_reg      <= lose_next;
    end
  end

  assign bus.G1000     = guess_reg[3];
  assign bus.G100      = guess_reg[2];
  assign bus.G10       = guess_reg[1];
  assign bus.G1        = guess_reg[0];
  assign bus.entry_cnt = entry_cnt_reg;
  assign bus.tries     = tries_reg;
  assign bus.too_high  = too_high_reg;
  assign bus.too_low   = too_low_reg;
  assign bus.win       = win_reg;
  assign bus.lose      = lose_reg;
  assign bus.playing   = (state_reg == ENTRY) || (state_reg == CHECK);

endmodule

// File: tb/tb_bcd_guess_checker.sv
// Random and directed check of bcd_guess_checker against a numeric game model.
// Two instances (8 tries and 2 tries) receive identical stimulus.
module tb_bcd_guess_checker;
  localparam int TRY_W = 4;
  localparam int M_IDLE = 0, M_ENTRY = 1, M_CHECK = 2, M_WIN = 3, M_LOSE = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       new_game = 1'b0;
  logic [3:0] T1000 = '0, T100 = '0, T10 = '0, T1 = '0;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = '0;
  logic       key_clear = 1'b0;
  logic       key_enter = 1'b0;

  bcd_guess_checker_if #(.TRY_W(TRY_W)) bus_a();
  bcd_guess_checker_if #(.TRY_W(TRY_W)) bus_b();

  assign bus_a.new_game = new_game;   assign bus_b.new_game = new_game;
  assign bus_a.T1000 = T1000;         assign bus_b.T1000 = T1000;
  assign bus_a.T100 = T100;           assign bus_b.T100 = T100;
  assign bus_a.T10 = T10;             assign bus_b.T10 = T10;
  assign bus_a.T1 = T1;               assign bus_b.T1 = T1;
  assign bus_a.key_valid = key_valid; assign bus_b.key_valid = key_valid;
  assign bus_a.key_digit = key_digit; assign bus_b.key_digit = key_digit;
  assign bus_a.key_clear = key_clear; assign bus_b.key_clear = key_clear;
  assign bus_a.key_enter = key_enter; assign bus_b.key_enter = key_enter;

  bcd_guess_checker #(.MAX_TRIES(8), .TRY_W(TRY_W)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  bcd_guess_checker #(.MAX_TRIES(2), .TRY_W(TRY_W)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int tests = 0;
  int fails = 0;

  // Game model: target and guess kept as decimal integers.
  int m_mode[2], m_target[2], m_guess[2], m_cnt[2], m_tries[2];
  int m_hi[2], m_lo[2], m_win[2], m_lose[2];
  int max_tries[2] = '{8, 2};
  bit started = 1'b0;

  function void model_step(int i);
    if (!rst) begin
      m_mode[i] = M_IDLE; m_target[i] = 0; m_guess[i] = 0; m_cnt[i] = 0; m_tries[i] = 0;
      m_hi[i] = 0; m_lo[i] = 0; m_win[i] = 0; m_lose[i] = 0;
    end else if (new_game) begin
      m_target[i] = int'(T1000) * 1000 + int'(T100) * 100 + int'(T10) * 10 + int'(T1);
      m_mode[i] = M_ENTRY; m_guess[i] = 0; m_cnt[i] = 0; m_tries[i] = 0;
      m_hi[i] = 0; m_lo[i] = 0; m_win[i] = 0; m_lose[i] = 0;
    end else if (m_mode[i] == M_ENTRY) begin
      if (key_clear) begin
        m_guess[i] = 0; m_cnt[i] = 0;
      end else if (key_enter) begin
        if (m_cnt[i] == 4) m_mode[i] = M_CHECK;
      end else if (key_valid && key_digit <= 9 && m_cnt[i] < 4) begin
        m_guess[i] = m_guess[i] * 10 + int'(key_digit);
        m_cnt[i]   = m_cnt[i] + 1;
      end
    end else if (m_mode[i] == M_CHECK) begin
      m_tries[i] = m_tries[i] + 1;
      if (m_guess[i] == m_target[i]) begin
        m_win[i] = 1; m_hi[i] = 0; m_lo[i] = 0; m_mode[i] = M_WIN;
      end else begin
        m_hi[i] = (m_guess[i] > m_target[i]) ? 1 : 0;
        m_lo[i] = (m_guess[i] < m_target[i]) ? 1 : 0;
        if (m_tries[i] == max_tries[i]) begin
          m_lose[i] = 1; m_mode[i] = M_LOSE;
`ifdef BCD_GUESS_REVEAL_EN
          m_guess[i] = m_target[i]; m_cnt[i] = 4;
`endif
        end else begin
          m_guess[i] = 0; m_cnt[i] = 0; m_mode[i] = M_ENTRY;
        end
      end
    end
  endfunction

  function logic [27:0] model_pack(int i);
    int g;
    g = m_guess[i];
    return {4'(g / 1000), 4'((g / 100) % 10), 4'((g / 10) % 10), 4'(g % 10),
            3'(m_cnt[i]), 4'(m_tries[i]), 1'(m_hi[i]), 1'(m_lo[i]), 1'(m_win[i]),
            1'(m_lose[i]), 1'(m_mode[i] == M_ENTRY || m_mode[i] == M_CHECK)};
  endfunction

  wire [27:0] pack_a = {bus_a.G1000, bus_a.G100, bus_a.G10, bus_a.G1, bus_a.entry_cnt,
                        bus_a.tries, bus_a.too_high, bus_a.too_low, bus_a.win, bus_a.lose,
                        bus_a.playing};
  wire [27:0] pack_b = {bus_b.G1000, bus_b.G100, bus_b.G10, bus_b.G1, bus_b.entry_cnt,
                        bus_b.tries, bus_b.too_high, bus_b.too_low, bus_b.win, bus_b.lose,
                        bus_b.playing};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_step(i);
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      logic [27:0] exp_a, exp_b;
      exp_a = model_pack(0);
      exp_b = model_pack(1);
      tests++;
      if (pack_a !== exp_a) begin
        fails++;
        $display("FAIL cycle_a at %0t: got %h expected %h", $time, pack_a, exp_a);
      end
      tests++;
      if (pack_b !== exp_b) begin
        fails++;
        $display("FAIL cycle_b at %0t: got %h expected %h", $time, pack_b, exp_b);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end else begin
      $display("[TB] %s ok: %h", name, got);
    end
  endtask

  task automatic tick(input logic ng, input logic v, input logic [3:0] d,
                      input logic c, input logic e);
    @(negedge clk);
    new_game = ng; key_valid = v; key_digit = d; key_clear = c; key_enter = e;
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic key(input int d);
    tick(1'b0, 1'b1, 4'(d), 1'b0, 1'b0);
  endtask

  task automatic enter();
    tick(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
  endtask

  task automatic start(input int t);
    @(negedge clk);
    T1000 = 4'(t / 1000); T100 = 4'((t / 100) % 10); T10 = 4'((t / 10) % 10); T1 = 4'(t % 10);
    new_game = 1'b1; key_valid = 1'b0; key_clear = 1'b0; key_enter = 1'b0;
  endtask

  task automatic enter_guess(input int g, input bit noisy);
    int digs[4];
    digs[0] = g / 1000; digs[1] = (g / 100) % 10; digs[2] = (g / 10) % 10; digs[3] = g % 10;
    for (int k = 0; k < 4; k++) begin
      if (noisy && $urandom_range(0, 3) == 0) idle();
      if (noisy && $urandom_range(0, 5) == 0) key($urandom_range(10, 15));
      key(digs[k]);
    end
    enter();
  endtask

  initial begin
    int g;
    idle(); idle();
    chk("reset_outputs_a", {4'd0, pack_a}, 32'd0);
    chk("reset_outputs_b", {4'd0, pack_b}, 32'd0);
    rst = 1'b1;

    // Win on first try.
    start(4702);
    key(4); key(7); key(0); key(2); enter();
    idle();
    chk("check_state_playing", {31'd0, bus_a.playing}, 32'd1);
    idle();
    chk("win_flag", {31'd0, bus_a.win}, 32'd1);
    chk("win_tries", {28'd0, bus_a.tries}, 32'd1);
    chk("win_flags_hl", {30'd0, bus_a.too_high, bus_a.too_low}, 32'd0);
    chk("win_playing", {31'd0, bus_a.playing}, 32'd0);

    // Too high then too low.
    start(5000);
    enter_guess(6000, 1'b0); idle(); idle();
    chk("too_high", {31'd0, bus_a.too_high}, 32'd1);
    chk("guess_cleared", {13'd0, bus_a.G1000, bus_a.G100, bus_a.G10, bus_a.G1, bus_a.entry_cnt}, 32'd0);
    enter_guess(4999, 1'b0); idle(); idle();
    chk("too_low_flags", {30'd0, bus_a.too_high, bus_a.too_low}, 32'd1);
    chk("tries_two", {28'd0, bus_a.tries}, 32'd2);

    // Entry limits: early enter, fifth digit and non-BCD digit are ignored.
    key(1); key(2); key(3); enter(); key(4); key(5); key(11); idle();
    chk("guess_1234", {16'd0, bus_a.G1000, bus_a.G100, bus_a.G10, bus_a.G1}, 32'h1234);
    chk("entry_cnt_4", {29'd0, bus_a.entry_cnt}, 32'd4);

    // Clear wins over enter and digit in the same cycle.
    tick(1'b0, 1'b1, 4'd7, 1'b1, 1'b1); idle();
    chk("clear_priority", {12'd0, bus_a.G1000, bus_a.G100, bus_a.G10, bus_a.G1, bus_a.entry_cnt, bus_a.playing}, 32'd1);

    // Two-try instance loses.
    start(9);
    enter_guess(1, 1'b0); idle(); idle();
    enter_guess(2, 1'b0); idle(); idle();
    chk("lose_flag_b", {31'd0, bus_b.lose}, 32'd1);
    chk("lose_tries_b", {28'd0, bus_b.tries}, 32'd2);
`ifdef BCD_GUESS_REVEAL_EN
    chk("lose_guess_b", {16'd0, bus_b.G1000, bus_b.G100, bus_b.G10, bus_b.G1}, 32'h0009);
`else
    chk("lose_guess_b", {16'd0, bus_b.G1000, bus_b.G100, bus_b.G10, bus_b.G1}, 32'h0002);
`endif
    tick(1'b0, 1'b1, 4'd5, 1'b1, 1'b1); idle();
    chk("lose_sticky_b", {31'd0, bus_b.lose}, 32'd1);
    start(1234); idle();
    chk("new_game_clears_b", {27'd0, bus_b.lose, bus_b.tries}, 32'd0);

    // Reset mid-entry.
    key(1); key(2);
    idle(); rst = 1'b0;
    idle(); rst = 1'b1;
    chk("rst_mid_game_a", {4'd0, pack_a}, 32'd0);
    key(3); key(4); enter(); idle();
    chk("idle_ignores_keys", {4'd0, pack_a}, 32'd0);

    // Random games with noisy entry.
    for (int n = 0; n < 40; n++) begin
      start(int'($urandom_range(0, 9999)));
      for (int t = 0; t < 10; t++) begin
        g = ($urandom_range(0, 3) == 0) ? m_target[0] : int'($urandom_range(0, 9999));
        if ($urandom_range(0, 9) == 0) begin
          key(3); tick(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        end
        enter_guess(g, 1'b1);
        idle(); idle();
        if (m_mode[0] != M_ENTRY) break;
      end
    end

    // Unconstrained input chaos, including stray resets and new games.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 299) != 0);
      new_game  = ($urandom_range(0, 59) == 0);
      T1000 = 4'($urandom_range(0, 9)); T100 = 4'($urandom_range(0, 9));
      T10   = 4'($urandom_range(0, 9)); T1   = 4'($urandom_range(0, 9));
      key_valid = ($urandom_range(0, 9) < 4);
      key_digit = 4'($urandom_range(0, 12));
      key_clear = ($urandom_range(0, 32) == 0);
      key_enter = ($urandom_range(0, 6) == 0);
    end
    rst = 1'b1;
    idle(); idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
